// File: rtl/copperv_bus_arbiter.sv
// copperv_bus_arbiter: shares one memory bus between fetch and load/store.
// Optional round-robin arbitration via `define COPPERV_ARB_ROUND_ROBIN_EN.
module copperv_bus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STRB_WIDTH   = DATA_WIDTH/8,
  parameter int RESP_TIMEOUT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  i_resp_valid,
  input  logic                  i_resp_ready,
  output logic [DATA_WIDTH-1:0] i_resp_rdata,
  output logic                  i_resp_err,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic                  d_req_write,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  input  logic [STRB_WIDTH-1:0] d_req_strobe,
  output logic                  d_resp_valid,
  input  logic                  d_resp_ready,
  output logic [DATA_WIDTH-1:0] d_resp_rdata,
  output logic                  d_resp_err,
  output logic                  m_req_valid,
  input  logic                  m_req_ready,
  output logic [ADDR_WIDTH-1:0] m_req_addr,
  output logic                  m_req_write,
  output logic [DATA_WIDTH-1:0] m_req_wdata,
  output logic [STRB_WIDTH-1:0] m_req_strobe,
  input  logic                  m_resp_valid,
  output logic                  m_resp_ready,
  input  logic [DATA_WIDTH-1:0] m_resp_rdata,
  input  logic                  m_resp_wok,
  output logic                  timeout_err
);

  localparam int CW = (RESP_TIMEOUT > 1) ?
    $clog2(RESP_TIMEOUT + 1) : 1;
  localparam bit TO_EN = (RESP_TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            grant_d;
  logic            wr_l;
  logic [CW-1:0]   cnt;
  logic            any_req;
  logic            pick_d;
  logic            to_act;

  assign any_req = i_req_valid | d_req_valid;
  assign to_act  = TO_EN && (cnt == CW'(RESP_TIMEOUT));

`ifdef COPPERV_ARB_ROUND_ROBIN_EN
  logic rr_d;

  assign pick_d = d_req_valid & (~i_req_valid | rr_d);

  // preference flips away from whichever port was just granted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_d <= 1'b1;
    end else if (state == IDLE && any_req) begin
      rr_d <= ~pick_d;
    end
  end
`else
  assign pick_d = d_req_valid;
`endif

  // grant, write latch, timeout counter and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant_d     <= 1'b0;
      wr_l        <= 1'b0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        grant_d <= pick_d;
      end
      if (state == REQ && m_req_ready) begin
        cnt  <= '0;
        wr_l <= grant_d & d_req_write;
      end else if (state == RESP && TO_EN &&
                   !to_act && !m_resp_valid) begin
        cnt <= cnt + CW'(1);
      end
      if (state == RESP && to_act) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // next state and bus muxing; everything is held at 0 in reset
  always_comb begin
    state_nx     = state;
    i_req_ready  = 1'b0;
    d_req_ready  = 1'b0;
    i_resp_valid = 1'b0;
    i_resp_rdata = '0;
    i_resp_err   = 1'b0;
    d_resp_valid = 1'b0;
    d_resp_rdata = '0;
    d_resp_err   = 1'b0;
    m_req_valid  = 1'b0;
    m_req_addr   = '0;
    m_req_write  = 1'b0;
    m_req_wdata  = '0;
    m_req_strobe = '0;
    m_resp_ready = 1'b0;
    if (rst) begin
      unique case (state)
        IDLE: begin
          m_resp_ready = 1'b1;
          if (any_req) state_nx = REQ;
        end
        REQ: begin
          m_req_valid = 1'b1;
          if (grant_d) begin
            m_req_addr   = d_req_addr;
            m_req_write  = d_req_write;
            m_req_wdata  = d_req_wdata;
            m_req_strobe = d_req_strobe;
            d_req_ready  = m_req_ready;
          end else begin
            m_req_addr  = i_req_addr;
            i_req_ready = m_req_ready;
          end
          if (m_req_ready) state_nx = RESP;
        end
        RESP: begin
          if (to_act) begin
            if (grant_d) begin
              d_resp_valid = 1'b1;
              d_resp_err   = 1'b1;
              if (d_resp_ready) state_nx = IDLE;
            end else begin
              i_resp_valid = 1'b1;
              i_resp_err   = 1'b1;
              if (i_resp_ready) state_nx = IDLE;
            end
          end else if (grant_d) begin
            d_resp_valid = m_resp_valid;
            d_resp_rdata = m_resp_rdata;
            d_resp_err   = wr_l & ~m_resp_wok;
            m_resp_ready = d_resp_ready;
            if (m_resp_valid && d_resp_ready)
              state_nx = IDLE;
          end else begin
            i_resp_valid = m_resp_valid;
            i_resp_rdata = m_resp_rdata;
            m_resp_ready = i_resp_ready;
            if (m_resp_valid && i_resp_ready)
              state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule
